// File: rtl/tlut_adder_tree_pipe.sv
// tlut_adder_tree_pipe: pipelined binary adder tree that reduces TLUT product
// terms into NOUT matrix-product elements. It uses valid/ready flow control
// with bubble collapsing.
//
// Handshake: a beat moves on the input when in_valid & in_ready, and on the
// output when out_valid & out_ready. out_valid/mult/out_sat come straight from
// the last stage registers. They hold while out_valid & ~out_ready.
//
// Optional feature: define ADDER_TREE_SAT_EN to clamp each final sum to the
// signed ACC_WIDTH range and report clamping on out_sat. Without it, sums wrap
// and out_sat is always 0.
module tlut_adder_tree_pipe #(
  parameter int DIM_ROW1  = 2,
  parameter int DIM_COL1  = 4,
  parameter int DIM_COL2  = 2,
  parameter int ACC_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DIM_ROW1*DIM_COL2*DIM_COL1-1:0][ACC_WIDTH-1:0] prod,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DIM_ROW1*DIM_COL2-1:0][ACC_WIDTH-1:0] mult,
  output logic                                      out_sat
);

  localparam int NOUT   = DIM_ROW1 * DIM_COL2;
  localparam int STAGES = (DIM_COL1 <= 1) ? 1 : $clog2(DIM_COL1);
  localparam int SW     = ACC_WIDTH + STAGES;          // growth-proof sum width
  localparam int PS     = (STAGES > 1) ? STAGES - 1 : 1; // wide intermediate stages

  // Intermediate stages keep a full DIM_COL1-wide slot array per group. Slots
  // beyond the live term count of a level are always zero. So "pair add" with a
  // zero partner is exactly the pass-through of an odd leftover term.
  logic signed [SW-1:0] pipe_q [PS][NOUT][DIM_COL1];
  logic signed [SW-1:0] nxt    [STAGES][NOUT][DIM_COL1];
  logic signed [SW-1:0] lvl    [2*DIM_COL1];

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] vin;
  logic              accept;
  logic              ld_last;
  logic              full;

  logic [NOUT-1:0][ACC_WIDTH-1:0] mult_q;
  logic [NOUT-1:0][ACC_WIDTH-1:0] mult_d;
  logic                           sat_q;
  logic                           sat_d;

  // Stage load enables: a stage may load unless it and every stage after it is
  // full while the output is stalled.
  always_comb begin
    load = '0;
    vin  = '0;
    full = 1'b1;
    for (int s = 0; s < STAGES; s++) begin
      full = 1'b1;
      for (int t = s; t < STAGES; t++) full = full & v_q[t];
      load[s] = ~full | out_ready;
    end
    in_ready = load[0] & ~flush;
    accept   = in_valid & in_ready;
    vin[0]   = accept;
    for (int s = 1; s < STAGES; s++) vin[s] = v_q[s-1];
    ld_last  = load[STAGES-1] & vin[STAGES-1] & ~flush;
  end

  // Tree levels: each stage adds adjacent pairs of the previous level.
  always_comb begin
    for (int s = 0; s < STAGES; s++)
      for (int n = 0; n < NOUT; n++)
        for (int j = 0; j < DIM_COL1; j++) nxt[s][n][j] = '0;
    for (int i = 0; i < 2*DIM_COL1; i++) lvl[i] = '0;
    for (int n = 0; n < NOUT; n++) begin
      for (int i = 0; i < 2*DIM_COL1; i++) lvl[i] = '0;
      for (int i = 0; i < DIM_COL1; i++)
        lvl[i] = {{STAGES{prod[n*DIM_COL1+i][ACC_WIDTH-1]}}, prod[n*DIM_COL1+i]};
      for (int j = 0; j < DIM_COL1; j++) nxt[0][n][j] = lvl[2*j] + lvl[2*j+1];
    end
    for (int s = 1; s < STAGES; s++) begin
      for (int n = 0; n < NOUT; n++) begin
        for (int i = 0; i < 2*DIM_COL1; i++) lvl[i] = '0;
        for (int i = 0; i < DIM_COL1; i++) lvl[i] = pipe_q[s-1][n][i];
        for (int j = 0; j < DIM_COL1; j++) nxt[s][n][j] = lvl[2*j] + lvl[2*j+1];
      end
    end
  end

  // Final narrowing to ACC_WIDTH: clamp (with saturation flag) or wrap.
  always_comb begin
    mult_d = '0;
    sat_d  = 1'b0;
    for (int n = 0; n < NOUT; n++) begin
`ifdef ADDER_TREE_SAT_EN
      // In range only when the bits above the ACC_WIDTH sign bit all match it.
      if ((&nxt[STAGES-1][n][0][SW-1:ACC_WIDTH-1]) |
          (~|nxt[STAGES-1][n][0][SW-1:ACC_WIDTH-1])) begin
        mult_d[n] = nxt[STAGES-1][n][0][ACC_WIDTH-1:0];
      end else begin
        mult_d[n] = nxt[STAGES-1][n][0][SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        sat_d     = 1'b1;
      end
`else
      mult_d[n] = nxt[STAGES-1][n][0][ACC_WIDTH-1:0];
`endif
    end
  end

  // Pipeline registers. The output registers only load real beats, so mult
  // holds its last value across bubbles and flushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      mult_q <= '0;
      sat_q  <= 1'b0;
      for (int s = 0; s < PS; s++)
        for (int n = 0; n < NOUT; n++)
          for (int j = 0; j < DIM_COL1; j++) pipe_q[s][n][j] <= '0;
    end else begin
      for (int s = 0; s < STAGES - 1; s++)
        if (load[s]) pipe_q[s] <= nxt[s];
      if (ld_last) begin
        mult_q <= mult_d;
        sat_q  <= sat_d;
      end
      if (flush) begin
        v_q <= '0;
      end else begin
        for (int s = 0; s < STAGES; s++)
          if (load[s]) v_q[s] <= vin[s];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign mult      = mult_q;
  assign out_sat   = sat_q;

endmodule
